// File: rtl/vai_mux_pkg.sv
// Shared VAI mux definitions: a trimmed CCI-P Rx type set plus the VMID tag helpers
// used by both the Tx tagging stage and the Rx steering stage.
package vai_mux_pkg;

   localparam int MMIO_WIN_SHIFT = 6;
   localparam int CCIP_CLDATA_WIDTH = 512;

   typedef struct packed {
      logic [1:0]  vc_used;
      logic        rsvd1;
      logic        hit_miss;
      logic [1:0]  rsvd0;
      logic [1:0]  cl_num;
      logic [3:0]  resp_type;
      logic [15:0] mdata;
   } t_ccip_c0_RspMemHdr;

   // Same width as the memory response header so both share the c0 hdr field.
   typedef struct packed {
      logic [15:0] address;
      logic [1:0]  length;
      logic        rsvd;
      logic [8:0]  tid;
   } t_ccip_c0_ReqMmioHdr;

   typedef struct packed {
      logic [1:0]  vc_used;
      logic        rsvd1;
      logic        hit_miss;
      logic        format;
      logic        rsvd0;
      logic [1:0]  cl_num;
      logic [3:0]  resp_type;
      logic [15:0] mdata;
   } t_ccip_c1_RspMemHdr;

   typedef struct packed {
      t_ccip_c0_RspMemHdr           hdr;
      logic [CCIP_CLDATA_WIDTH-1:0] data;
      logic                         rspValid;
      logic                         mmioRdValid;
      logic                         mmioWrValid;
   } t_if_ccip_c0_Rx;

   typedef struct packed {
      t_ccip_c1_RspMemHdr hdr;
      logic               rspValid;
   } t_if_ccip_c1_Rx;

   typedef struct packed {
      logic           c0TxAlmFull;
      logic           c1TxAlmFull;
      t_if_ccip_c0_Rx c0;
      t_if_ccip_c1_Rx c1;
   } t_if_ccip_Rx;

   // VMID lives in the top $clog2(num) bits of mdata.
   function automatic logic [6:0] vai_vmid(input logic [15:0] mdata, input int num);
      int w;
      w = $clog2(num);
      return 7'(mdata >> (16 - w));
   endfunction

   function automatic logic [15:0] vai_untag(input logic [15:0] mdata, input int num);
      return mdata & (16'hFFFF >> $clog2(num));
   endfunction

endpackage

// File: rtl/vai_serve_rx.sv
// VAI mux Rx demultiplexer: steers tagged memory responses and windowed MMIO requests
// from the single upstream Rx port to per-AFU Rx ports, two-stage registered.
module vai_serve_rx
   import vai_mux_pkg::*;
#(
   parameter int NUM_SUB_AFUS = 8
)
(
   input  logic                                 clk,
   input  logic                                 reset,
   input  t_if_ccip_Rx                          up_RxPort,
   input  logic [NUM_SUB_AFUS-1:0]              tx_fifo_alm_full_c0,
   input  logic [NUM_SUB_AFUS-1:0]              tx_fifo_alm_full_c1,
   output t_if_ccip_Rx [NUM_SUB_AFUS-1:0]       afu_RxPort,
   output t_if_ccip_c0_Rx                       mgr_c0,
   output logic [15:0]                          stray_cnt
);

   localparam logic [6:0] NUM_VMID = 7'(NUM_SUB_AFUS);
   localparam logic [9:0] NUM_WIN  = 10'(NUM_SUB_AFUS);

   t_if_ccip_c0_Rx c0_d, c0_q;
   t_if_ccip_c1_Rx c1_d, c1_q;
   t_if_ccip_c0_Rx mgr_d, mgr_q;
   logic [15:0]    stray_cnt_d, stray_cnt_q;

   logic [6:0]          c0_vmid, c1_vmid;
   logic                c0_stray, c1_stray;
   t_ccip_c0_ReqMmioHdr mmio_hdr, mmio_rebased;
   logic [9:0]          win, afu_idx;
   logic                in_win;
   t_ccip_c0_RspMemHdr  c0_hdr;
   t_ccip_c1_RspMemHdr  c1_hdr;
   logic [16:0]         stray_sum;

   always_comb begin
      c0_d = up_RxPort.c0;
      c1_d = up_RxPort.c1;
   end

   // R1: capture the upstream channels
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         c0_q <= '0;
         c1_q <= '0;
      end else begin
         c0_q <= c0_d;
         c1_q <= c1_d;
      end
   end

   // Shared decode, one per channel; every AFU compares its own index against it.
   always_comb begin
      c0_vmid  = vai_vmid(c0_q.hdr.mdata, NUM_SUB_AFUS);
      c1_vmid  = vai_vmid(c1_q.hdr.mdata, NUM_SUB_AFUS);
      c0_stray = c0_q.rspValid && (c0_vmid >= NUM_VMID);
      c1_stray = c1_q.rspValid && (c1_vmid >= NUM_VMID);

      mmio_hdr = t_ccip_c0_ReqMmioHdr'(c0_q.hdr);
      win      = mmio_hdr.address[15:MMIO_WIN_SHIFT];
      in_win   = (win >= 10'd1) && (win <= NUM_WIN);
      afu_idx  = win - 10'd1;

      mmio_rebased         = mmio_hdr;
      mmio_rebased.address = {10'b0, mmio_hdr.address[MMIO_WIN_SHIFT-1:0]};

      c0_hdr = c0_q.hdr;
      if (c0_q.rspValid) begin
         c0_hdr.mdata = vai_untag(c0_q.hdr.mdata, NUM_SUB_AFUS);
      end else begin
         c0_hdr = t_ccip_c0_RspMemHdr'(mmio_rebased);
      end

      c1_hdr       = c1_q.hdr;
      c1_hdr.mdata = vai_untag(c1_q.hdr.mdata, NUM_SUB_AFUS);
   end

   for (genvar n = 0; n < NUM_SUB_AFUS; n++) begin : g_afu
      t_if_ccip_Rx afu_d, afu_q;

      // Headers and data are shared by all AFUs; only the valids are per-AFU.
      always_comb begin
         afu_d                = '0;
         afu_d.c0TxAlmFull    = up_RxPort.c0TxAlmFull | tx_fifo_alm_full_c0[n];
         afu_d.c1TxAlmFull    = up_RxPort.c1TxAlmFull | tx_fifo_alm_full_c1[n];
         afu_d.c0.hdr         = c0_hdr;
         afu_d.c0.data        = c0_q.data;
         afu_d.c0.rspValid    = c0_q.rspValid && (c0_vmid == 7'(n));
         afu_d.c0.mmioRdValid = c0_q.mmioRdValid && in_win && (afu_idx == 10'(n));
         afu_d.c0.mmioWrValid = c0_q.mmioWrValid && in_win && (afu_idx == 10'(n));
         afu_d.c1.hdr         = c1_hdr;
         afu_d.c1.rspValid    = c1_q.rspValid && (c1_vmid == 7'(n));
      end

      // R2: per-AFU output register
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            afu_q <= '0;
         end else begin
            afu_q <= afu_d;
         end
      end

      assign afu_RxPort[n] = afu_q;
   end

   always_comb begin
      mgr_d             = c0_q;
      mgr_d.rspValid    = 1'b0;
      mgr_d.mmioRdValid = c0_q.mmioRdValid && !in_win;
      mgr_d.mmioWrValid = c0_q.mmioWrValid && !in_win;

      stray_sum = 17'(stray_cnt_q) + 17'(c0_stray) + 17'(c1_stray);
      if (stray_sum[16]) begin
         stray_cnt_d = 16'hFFFF;
      end else begin
         stray_cnt_d = stray_sum[15:0];
      end
   end

   // R2: manager port and stray counter, aligned with the per-AFU outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mgr_q       <= '0;
         stray_cnt_q <= 16'h0000;
      end else begin
         mgr_q       <= mgr_d;
         stray_cnt_q <= stray_cnt_d;
      end
   end

   assign mgr_c0    = mgr_q;
   assign stray_cnt = stray_cnt_q;

endmodule
